// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage light_rv32i core.
// Latency: zero-cycle Mealy outputs from state + hazard inputs.
// Backpressure: a data-memory wait freezes the whole pipe; a load-use hazard freezes PC/IF/ID for one bubble.
//
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_hazard_IFID_Reg1/Reg2           rs1/rs2 of the ID instruction
//   i_hazard_IFID_UseReg1/UseReg2     ID instruction really reads rs1/rs2
//   i_hazard_IDEX_RegDst, _MemRdEn    rd of the EX instruction, EX is a load
//   i_hazard_EX_Redirect              taken branch / jal / jalr resolved in EX
//   i_hazard_EXM_MemReq, _DMemReady   MEM access pending, data memory completes
//   o_hazard_PCEn, _IFIDEn, _IDEXEn, _EXMEn       pipeline register enables
//   o_hazard_IFIDFlush, _IDEXFlush, _MWBFlush     bubble insertion
//   o_hazard_BusErr                   sticky data-memory timeout flag
//   o_hazard_StallCnt                 saturating count of PC-stall cycles
module hazard_ctrl #(
  parameter int INIT_CYC = 2,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_hazard_IFID_Reg1,
  input  logic [4:0]       i_hazard_IFID_Reg2,
  input  logic             i_hazard_IFID_UseReg1,
  input  logic             i_hazard_IFID_UseReg2,
  input  logic [4:0]       i_hazard_IDEX_RegDst,
  input  logic             i_hazard_IDEX_MemRdEn,
  input  logic             i_hazard_EX_Redirect,
  input  logic             i_hazard_EXM_MemReq,
  input  logic             i_hazard_DMemReady,
  output logic             o_hazard_PCEn,
  output logic             o_hazard_IFIDEn,
  output logic             o_hazard_IFIDFlush,
  output logic             o_hazard_IDEXEn,
  output logic             o_hazard_IDEXFlush,
  output logic             o_hazard_EXMEn,
  output logic             o_hazard_MWBFlush,
  output logic             o_hazard_BusErr,
  output logic [CNT_W-1:0] o_hazard_StallCnt
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_WAIT, ST_ERR} state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);
  localparam logic [8:0] TO_LIM    = 9'(TIMEOUT);

  state_t           state, state_nxt;
  logic [3:0]       init_cnt, init_cnt_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             bus_err, bus_err_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic dmem_stall;
  logic load_use;
  logic count_en;

  // In WAIT, a dropped MemReq reads as "not stalled", which is exactly the abort case.
  assign dmem_stall = i_hazard_EXM_MemReq && !i_hazard_DMemReady;

  assign load_use = i_hazard_IDEX_MemRdEn && (i_hazard_IDEX_RegDst != 5'd0) &&
                    ((i_hazard_IFID_UseReg1 && (i_hazard_IFID_Reg1 == i_hazard_IDEX_RegDst)) ||
                     (i_hazard_IFID_UseReg2 && (i_hazard_IFID_Reg2 == i_hazard_IDEX_RegDst)));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_cnt <= 4'd0;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    wait_cnt_nxt = wait_cnt;
    bus_err_nxt  = bus_err;
    unique case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt    = ST_RUN;
          init_cnt_nxt = 4'd0;
        end else begin
          init_cnt_nxt = init_cnt + 4'd1;
        end
      end
      ST_RUN: begin
        if (dmem_stall) begin
          // The stalled RUN cycle is the first wait cycle.
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!dmem_stall) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (({1'b0, wait_cnt} + 9'd1) >= TO_LIM) begin
          // Ready in this same cycle takes the branch above, so it wins.
          state_nxt    = ST_ERR;
          bus_err_nxt  = 1'b1;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Output logic. RUN and WAIT share one rule set: in WAIT the stall term is
  // simply the still-pending access, and on release Redirect/load-use apply.
  always_comb begin
    o_hazard_PCEn      = 1'b0;
    o_hazard_IFIDEn    = 1'b0;
    o_hazard_IFIDFlush = 1'b0;
    o_hazard_IDEXEn    = 1'b0;
    o_hazard_IDEXFlush = 1'b0;
    o_hazard_EXMEn     = 1'b0;
    o_hazard_MWBFlush  = 1'b0;
    count_en           = 1'b0;
    unique case (state)
      ST_INIT: begin
        o_hazard_IFIDFlush = 1'b1;
        o_hazard_IDEXFlush = 1'b1;
        o_hazard_MWBFlush  = 1'b1;
      end
      ST_RUN, ST_WAIT: begin
        if (dmem_stall) begin
          o_hazard_MWBFlush = 1'b1;
        end else if (i_hazard_EX_Redirect) begin
          // Squashes the dependent instruction, so load-use is moot.
          o_hazard_PCEn      = 1'b1;
          o_hazard_IFIDEn    = 1'b1;
          o_hazard_IFIDFlush = 1'b1;
          o_hazard_IDEXEn    = 1'b1;
          o_hazard_IDEXFlush = 1'b1;
          o_hazard_EXMEn     = 1'b1;
        end else if (load_use) begin
          o_hazard_IDEXEn    = 1'b1;
          o_hazard_IDEXFlush = 1'b1;
          o_hazard_EXMEn     = 1'b1;
        end else begin
          o_hazard_PCEn   = 1'b1;
          o_hazard_IFIDEn = 1'b1;
          o_hazard_IDEXEn = 1'b1;
          o_hazard_EXMEn  = 1'b1;
        end
        count_en = !o_hazard_PCEn;
      end
      default: begin
        count_en = 1'b0;
      end
    endcase
  end

  // Saturating stall counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (count_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_hazard_BusErr   = bus_err;
  assign o_hazard_StallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with INIT_CYC=2, TIMEOUT=4, CNT_W=4.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Control outputs are compared as one packed vector {PC,IFIDEn,IFIDFl,IDEXEn,IDEXFl,EXMEn,MWBFl}.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] reg1, reg2, regdst;
  logic       use1, use2, memrd, redir, memreq, rdy;
  logic       pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exm_en, mwb_fl, bus_err;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] V_INIT  = 7'b0010101;
  localparam logic [6:0] V_RUN   = 7'b1101010;
  localparam logic [6:0] V_STALL = 7'b0000001;
  localparam logic [6:0] V_REDIR = 7'b1111110;
  localparam logic [6:0] V_LU    = 7'b0001110;
  localparam logic [6:0] V_ERR   = 7'b0000000;

  hazard_ctrl #(.INIT_CYC(2), .TIMEOUT(4), .CNT_W(4)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_hazard_IFID_Reg1    (reg1),
    .i_hazard_IFID_Reg2    (reg2),
    .i_hazard_IFID_UseReg1 (use1),
    .i_hazard_IFID_UseReg2 (use2),
    .i_hazard_IDEX_RegDst  (regdst),
    .i_hazard_IDEX_MemRdEn (memrd),
    .i_hazard_EX_Redirect  (redir),
    .i_hazard_EXM_MemReq   (memreq),
    .i_hazard_DMemReady    (rdy),
    .o_hazard_PCEn         (pc_en),
    .o_hazard_IFIDEn       (ifid_en),
    .o_hazard_IFIDFlush    (ifid_fl),
    .o_hazard_IDEXEn       (idex_en),
    .o_hazard_IDEXFlush    (idex_fl),
    .o_hazard_EXMEn        (exm_en),
    .o_hazard_MWBFlush     (mwb_fl),
    .o_hazard_BusErr       (bus_err),
    .o_hazard_StallCnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ctl();
    return {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exm_en, mwb_fl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic r, input logic mq, input logic rd_ok, input logic ld,
                       input logic [4:0] dst, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
    redir  = r;
    memreq = mq;
    rdy    = rd_ok;
    memrd  = ld;
    regdst = dst;
    reg1   = r1;
    reg2   = r2;
    use1   = u1;
    use2   = u2;
  endtask

  task automatic clr();
    setin(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    clr();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 32'(ctl()), 32'(V_INIT));
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);

    // Test 1: two INIT cycles, then RUN
    @(negedge clk);
    rst = 1'b0;
    #1 chk("init_c1", 32'(ctl()), 32'(V_INIT));
    @(negedge clk);
    #1 chk("init_c2", 32'(ctl()), 32'(V_INIT));
    @(negedge clk);
    #1 chk("run_c3", 32'(ctl()), 32'(V_RUN));
    chk("run_c3_cnt", 32'(stall_cnt), 32'd0);

    // Test 2: load-use via rs2, then x0 and unused-operand cases
    @(negedge clk);
    setin(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    #1 chk("lu_rs2", 32'(ctl()), 32'(V_LU));
    @(negedge clk);
    clr();
    #1 chk("lu_after", 32'(ctl()), 32'(V_RUN));
    chk("lu_cnt1", 32'(stall_cnt), 32'd1);
    @(negedge clk);
    setin(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    #1 chk("lu_x0", 32'(ctl()), 32'(V_RUN));
    @(negedge clk);
    setin(0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0);
    #1 chk("lu_unused", 32'(ctl()), 32'(V_RUN));
    @(negedge clk);
    setin(0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 1);
    #1 chk("lu_rs1", 32'(ctl()), 32'(V_LU));
    @(negedge clk);
    clr();
    #1 chk("lu_cnt2", 32'(stall_cnt), 32'd2);

    // Test 3: redirect beats load-use
    @(negedge clk);
    setin(1, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    #1 chk("redir_lu", 32'(ctl()), 32'(V_REDIR));
    @(negedge clk);
    clr();
    #1 chk("redir_after", 32'(ctl()), 32'(V_RUN));
    chk("redir_cnt", 32'(stall_cnt), 32'd2);

    // Test 4: three dmem wait cycles with redirect pending, ready at TIMEOUT boundary
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setin(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      #1 chk("dmem_stall", 32'(ctl()), 32'(V_STALL));
    end
    @(negedge clk);
    setin(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #1 chk("dmem_release", 32'(ctl()), 32'(V_REDIR));
    chk("dmem_noerr", 32'(bus_err), 32'd0);
    @(negedge clk);
    clr();
    #1 chk("dmem_after", 32'(ctl()), 32'(V_RUN));
    chk("dmem_cnt", 32'(stall_cnt), 32'd5);

    // MemReq dropping in WAIT aborts back to RUN
    @(negedge clk);
    setin(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #1 chk("abort_stall", 32'(ctl()), 32'(V_STALL));
    @(negedge clk);
    clr();
    #1 chk("abort_rel", 32'(ctl()), 32'(V_RUN));
    @(negedge clk);
    #1 chk("abort_run", 32'(ctl()), 32'(V_RUN));
    chk("abort_cnt", 32'(stall_cnt), 32'd6);

    // Test 5: timeout after 4 wait cycles, ERR ignores inputs, async reset clears
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      setin(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      #1 chk("to_stall", 32'(ctl()), 32'(V_STALL));
      chk("to_noerr", 32'(bus_err), 32'd0);
    end
    @(negedge clk);
    #1 chk("err_ctl", 32'(ctl()), 32'(V_ERR));
    chk("err_buserr", 32'(bus_err), 32'd1);
    chk("err_cnt", 32'(stall_cnt), 32'd10);
    @(negedge clk);
    setin(1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
    #1 chk("err_hold", 32'(ctl()), 32'(V_ERR));
    chk("err_hold_be", 32'(bus_err), 32'd1);
    chk("err_hold_cnt", 32'(stall_cnt), 32'd10);
    #1 rst = 1'b1;
    #1 chk("arst_ctl", 32'(ctl()), 32'(V_INIT));
    chk("arst_buserr", 32'(bus_err), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);

    // Test 6: counter saturation with 20 load-use stalls
    clr();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("sat_run", 32'(ctl()), 32'(V_RUN));
    chk("sat_cnt0", 32'(stall_cnt), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      setin(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
      #1;
      @(negedge clk);
      clr();
      #1;
      if (i == 1)  chk("sat_cnt1", 32'(stall_cnt), 32'd1);
      if (i == 15) chk("sat_cnt15", 32'(stall_cnt), 32'd15);
    end
    chk("sat_cnt20", 32'(stall_cnt), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
